// File: rtl/uart_tx.sv
// uart_tx: byte-wide 8N1 (or 8N2) UART transmitter with a small input FIFO.
// Bytes enter through a valid/ready handshake, are queued, and are shifted
// out LSB-first at CLKS_PER_BIT clocks per bit. Back-to-back queued bytes
// are sent as contiguous frames with no idle gap between them.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign tx_ready = !full;
    assign push     = tx_valid && tx_ready;

    // Byte storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pointer and occupancy bookkeeping; a push and pop together cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    sh;
    logic [7:0]    sh_next;
    logic          tx_next;
    logic          done_next;

    // State, counters and the registered line/strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
            tx_done <= done_next;
        end
    end

    // Shift register holds the byte in flight; loaded on every pop.
    always_ff @(posedge clk) begin
        sh <= sh_next;
    end

    // Next-state logic; tx_next is the line level for the state being entered,
    // so the flopped tx changes on the same edge as the state.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        sh_next      = sh;
        pop          = 1'b0;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    sh_next      = mem[rd_ptr];
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (cnt == CNT_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (bit_idx == STOP_LAST) begin
                        done_next    = 1'b1;
                        bit_idx_next = '0;
                        if (!empty) begin
                            pop        = 1'b1;
                            sh_next    = mem[rd_ptr];
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                state_next   = IDLE;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh_next[bit_idx_next];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx_busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized bench for uart_tx. Three instances cover
// 16 clk/bit with one stop bit, 16 clk/bit with two stop bits, and 87 clk/bit.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dat [3];
    logic [2:0] vld;
    logic [2:0] txv;
    logic [2:0] rdy;
    logic [2:0] bsy;
    logic [2:0] dnp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt [3] = '{0, 0, 0};

    logic [7:0] dbuf [3][64];
    int dn [3];
    int stop_bad [3];
    bit dec_en [3];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx(txv[0]), .tx_busy(bsy[0]), .tx_done(dnp[0]));

    uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx(txv[1]), .tx_busy(bsy[1]), .tx_done(dnp[1]));

    uart_tx #(.CLKS_PER_BIT(87), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx(txv[2]), .tx_busy(bsy[2]), .tx_done(dnp[2]));

    // Cycle counter and per-instance tx_done pulse counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (dnp[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte for one clock; acc reports whether it was taken.
    task automatic push(input int id, input logic [7:0] b, output bit acc);
        dat[id] = b;
        vld[id] = 1'b1;
        acc = rdy[id];
        tick(1);
        vld[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id, input int limit, output int at);
        int n = 0;
        while (bsy[id] && n < limit) begin
            tick(1);
            n++;
        end
        at = cyc;
        check("idle_timeout", 32'(bsy[id]), 32'd0);
    endtask

    // Expected line level k cycles after the start-bit falling edge.
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int cpb);
        int slot;
        slot = k / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Serial receiver model: find a falling edge, sample each bit mid-bit.
    task automatic decode(input int id, input int cpb);
        logic       prev;
        logic       st;
        logic [7:0] b;
        prev = 1'b1;
        b = '0;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !txv[id]) begin
                repeat (cpb / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) @(negedge clk);
                    b[i] = txv[id];
                end
                repeat (cpb) @(negedge clk);
                st = txv[id];
                if (dec_en[id]) begin
                    if (dn[id] < 64) dbuf[id][dn[id]] = b;
                    dn[id] = dn[id] + 1;
                    if (st !== 1'b1) stop_bad[id] = stop_bad[id] + 1;
                end
                prev = st;
            end else begin
                prev = txv[id];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        bit         all_acc;
        int         x0;
        int         t;
        int         base;
        int         n_acc;
        logic [7:0] bv;
        logic [7:0] burst [6];
        logic [7:0] rexp [64];

        vld = '0;
        for (int i = 0; i < 3; i++) begin
            dat[i] = '0;
            dn[i] = 0;
            stop_bad[i] = 0;
            dec_en[i] = 1'b1;
        end
        fork
            decode(0, 16);
            decode(1, 16);
            decode(2, 87);
        join_none

        // Reset values while rst_n is held low.
        rst_n = 1'b0;
        tick(3);
        for (int i = 0; i < 3; i++)
            check("reset_state", 32'({txv[i], rdy[i], bsy[i], dnp[i]}), 32'hC);
        rst_n = 1'b1;

        // Quiet line after reset release with no writes.
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            check("idle_outputs", 32'({txv, rdy, bsy, dnp}), 32'hFC0);
        end

        // Single byte 0xA5, exact waveform and tx_done timing.
        bv = 8'hA5;
        dn[0] = 0;
        base = done_cnt[0];
        push(0, bv, acc);
        check("a5_accept", 32'(acc), 32'd1);
        check("a5_pre_start", 32'({txv[0], bsy[0]}), 32'h3);
        for (int k = 0; k < 160; k++) begin
            tick(1);
            check("a5_wave", 32'({txv[0], dnp[0]}), 32'({frame_bit(bv, k, 16), 1'b0}));
        end
        tick(1);
        check("a5_done_pulse", 32'({dnp[0], bsy[0], txv[0]}), 32'h5);
        tick(1);
        check("a5_done_single", 32'(dnp[0]), 32'd0);
        check("a5_done_count", 32'(done_cnt[0] - base), 32'd1);
        check("a5_decoded_n", 32'(dn[0]), 32'd1);
        check("a5_decoded", 32'(dbuf[0][0]), 32'hA5);

        // Six-byte burst into a depth-4 FIFO; sixth is refused then retried.
        burst = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80};
        dn[0] = 0;
        base = done_cnt[0];
        x0 = 0;
        for (int i = 0; i < 6; i++) begin
            push(0, burst[i], acc);
            if (i == 0) x0 = cyc;
            check("burst_accept", 32'(acc), (i < 5) ? 32'd1 : 32'd0);
        end
        t = 0;
        acc = 1'b0;
        while (!acc && t < 2000) begin
            push(0, burst[5], acc);
            t++;
        end
        check("burst_retry_edge", 32'(cyc - x0), 32'd162);
        wait_idle(0, 3000, t);
        check("burst_contiguous_end", 32'(t - x0), 32'd961);
        tick(2);
        check("burst_done_count", 32'(done_cnt[0] - base), 32'd6);
        check("burst_decoded_n", 32'(dn[0]), 32'd6);
        for (int i = 0; i < 6; i++)
            check("burst_decoded", 32'(dbuf[0][i]), 32'(burst[i]));

        // Asynchronous reset in the middle of data bit 4 with two bytes queued.
        push(0, 8'h11, acc);
        x0 = cyc;
        all_acc = acc;
        push(0, 8'h22, acc);
        all_acc = all_acc & acc;
        push(0, 8'h33, acc);
        all_acc = all_acc & acc;
        check("rst_queue_accept", 32'(all_acc), 32'd1);
        tick(x0 + 89 - cyc);
        check("rst_pre_bit4", 32'({txv[0], bsy[0]}), 32'h3);
        dec_en[0] = 1'b0;
        base = done_cnt[0];
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({txv[0], bsy[0], rdy[0]}), 32'h5);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            check("rst_quiet", 32'({txv[0], bsy[0]}), 32'h2);
        end
        check("rst_no_done", 32'(done_cnt[0] - base), 32'd0);
        dec_en[0] = 1'b1;

        // Two stop bits: 176-cycle frame, single tx_done.
        bv = 8'h3C;
        dn[1] = 0;
        base = done_cnt[1];
        push(1, bv, acc);
        check("s2_accept", 32'(acc), 32'd1);
        for (int k = 0; k < 176; k++) begin
            tick(1);
            check("s2_wave", 32'({txv[1], dnp[1]}), 32'({frame_bit(bv, k, 16), 1'b0}));
        end
        tick(1);
        check("s2_done_pulse", 32'({dnp[1], bsy[1], txv[1]}), 32'h5);
        tick(1);
        check("s2_done_count", 32'(done_cnt[1] - base), 32'd1);
        check("s2_decoded_n", 32'(dn[1]), 32'd1);
        check("s2_decoded", 32'(dbuf[1][0]), 32'h3C);

        // Random bytes at random gaps, 87 clocks per bit.
        dn[2] = 0;
        stop_bad[2] = 0;
        base = done_cnt[2];
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            tick($urandom_range(0, 300));
            bv = 8'($urandom);
            acc = 1'b0;
            t = 0;
            while (!acc && t < 5000) begin
                push(2, bv, acc);
                t++;
            end
            if (acc) begin
                rexp[n_acc] = bv;
                n_acc++;
            end
        end
        check("rand_all_accepted", 32'(n_acc), 32'd12);
        wait_idle(2, 20000, t);
        tick(2);
        check("rand_decoded_n", 32'(dn[2]), 32'(n_acc));
        check("rand_stop_bits", 32'(stop_bad[2]), 32'd0);
        check("rand_done_count", 32'(done_cnt[2] - base), 32'(n_acc));
        for (int i = 0; i < n_acc; i++)
            check("rand_decoded", 32'(dbuf[2][i]), 32'(rexp[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
